// File: rtl/secuencia_ctrl_if.sv
// Handshake bundle between secuencia_ctrl and its word source, result sink and "11" detector.
// Signals: in_valid/in_data/in_ready (word in), w/z (detector link), out_valid/out_count/
//          out_map/out_ready (result out), busy (status). master = controller side.
interface secuencia_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = $clog2(DATA_W + 1)
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              w;
   logic              z;
   logic              out_valid;
   logic [CNT_W-1:0]  out_count;
   logic [DATA_W-1:0] out_map;
   logic              out_ready;
   logic              busy;

   modport master (
      input  in_valid, in_data, z, out_ready,
      output in_ready, w, out_valid, out_count, out_map, busy
   );

   modport slave (
      output in_valid, in_data, z, out_ready,
      input  in_ready, w, out_valid, out_count, out_map, busy
   );
endinterface

// File: rtl/secuencia_ctrl.sv
// Bit-serial sequencer for the secuencia_mealy "11" detector: shifts each word MSB-first on w,
// samples z the same cycle, returns match count + position map. Result valid DATA_W+1 cycles
// after accept; result held in DONE until out_ready. Optional macro SECUENCIA_CTRL_ABORT_EN adds abort.
// Ports: clk, reset (async, active-low), bus (secuencia_ctrl_if.master), [abort].
module secuencia_ctrl #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = $clog2(DATA_W + 1)
) (
   input  logic clk,
   input  logic reset,
`ifdef SECUENCIA_CTRL_ABORT_EN
   input  logic abort,
`endif
   secuencia_ctrl_if.master bus
);
   localparam int IDX_W = $clog2(DATA_W);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] shreg;
   logic [IDX_W-1:0]  idx;
   logic [CNT_W-1:0]  count;
   logic [DATA_W-1:0] map;
   logic              abort_i;
   logic              accept;

`ifdef SECUENCIA_CTRL_ABORT_EN
   assign abort_i = abort;
`else
   assign abort_i = 1'b0;
`endif

   // abort in IDLE blocks the accept without dropping in_ready
   assign accept = (state == IDLE) && bus.in_valid && !abort_i;

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SHIFT;
         SHIFT: begin
            if (abort_i)                 state_nxt = IDLE;
            else if (idx == IDX_W'(0))   state_nxt = DONE;
         end
         DONE:    if (abort_i || bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // output logic; w is forced low outside SHIFT so the detector falls back to S0 between words
   always_comb begin
      bus.in_ready  = (state == IDLE);
      bus.w         = (state == SHIFT) ? shreg[DATA_W-1] : 1'b0;
      bus.out_valid = (state == DONE);
      bus.busy      = (state == SHIFT) || (state == DONE);
      bus.out_count = count;
      bus.out_map   = map;
   end

   // datapath: shift register, bit index, match count and map
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg <= '0;
         idx   <= '0;
         count <= '0;
         map   <= '0;
      end else if (abort_i && (state != IDLE)) begin
         count <= '0;
         map   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  shreg <= bus.in_data;
                  idx   <= IDX_W'(DATA_W - 1);
                  count <= '0;
                  map   <= '0;
               end
            end
            SHIFT: begin
               // z is combinational in the bit currently on w, so it belongs to map[idx]
               if (bus.z) begin
                  count    <= count + CNT_W'(1);
                  map[idx] <= 1'b1;
               end
               shreg <= {shreg[DATA_W-2:0], 1'b0};
               idx   <= idx - IDX_W'(1);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_secuencia_ctrl.sv
// Directed bench for secuencia_ctrl with a behavioural "11" Mealy detector closing the w/z loop.
module tb_secuencia_ctrl;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 4;

   logic clk;
   logic reset;
`ifdef SECUENCIA_CTRL_ABORT_EN
   logic abort;
`endif
   int   nchk;
   int   nerr;

   secuencia_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   secuencia_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
`ifdef SECUENCIA_CTRL_ABORT_EN
      .abort (abort),
`endif
      .bus   (bus.master)
   );

   // detector: S1 means previous w was 1; z = w while in S1 (overlapping detection)
   logic det_s1;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) det_s1 <= 1'b0;
      else        det_s1 <= bus.w;
   end
   assign bus.z = bus.w & det_s1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
      check({tag, "_w"},         32'(bus.w),         32'd0);
      check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_busy"},      32'(bus.busy),      32'd0);
   endtask

   // accept one word, check every shift cycle, hold the result for 'hold' cycles, then release
   task automatic run_word(input logic [7:0] data, input logic [3:0] exp_cnt,
                           input logic [7:0] exp_map, input int hold);
      bus.in_data  = data;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.in_data  = ~data;  // must not be re-sampled after the accept edge
      for (int k = 1; k <= DATA_W; k++) begin
         check("shift_w",         32'(bus.w),         32'(data[DATA_W-k]));
         check("shift_out_valid", 32'(bus.out_valid), 32'd0);
         check("shift_in_ready",  32'(bus.in_ready),  32'd0);
         check("shift_busy",      32'(bus.busy),      32'd1);
         tick();
      end
      check("done_out_valid", 32'(bus.out_valid), 32'd1);
      check("done_count",     32'(bus.out_count), 32'(exp_cnt));
      check("done_map",       32'(bus.out_map),   32'(exp_map));
      check("done_w",         32'(bus.w),         32'd0);
      check("done_in_ready",  32'(bus.in_ready),  32'd0);
      for (int h = 0; h < hold; h++) begin
         tick();
         check("hold_out_valid", 32'(bus.out_valid), 32'd1);
         check("hold_count",     32'(bus.out_count), 32'(exp_cnt));
         check("hold_map",       32'(bus.out_map),   32'(exp_map));
         check("hold_w",         32'(bus.w),         32'd0);
         check("hold_in_ready",  32'(bus.in_ready),  32'd0);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check_idle("release");
   endtask

   initial begin
      nchk          = 0;
      nerr          = 0;
      reset         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
`ifdef SECUENCIA_CTRL_ABORT_EN
      abort         = 1'b0;
`endif
      #2;
      check_idle("reset");
      check("reset_count", 32'(bus.out_count), 32'd0);
      check("reset_map",   32'(bus.out_map),   32'd0);
      repeat (2) tick();
      reset = 1'b1;
      repeat (5) tick();
      check_idle("quiet");
      check("quiet_count", 32'(bus.out_count), 32'd0);

      // all ones: overlapping matches on every bit but the first
      run_word(8'hFF, 4'd7, 8'b0111_1111, 0);
      // mixed pattern, then back-to-back words with no cross-word matching
      run_word(8'hB6, 4'd2, 8'b0001_0010, 0);
      run_word(8'h00, 4'd0, 8'h00, 0);
      run_word(8'hAA, 4'd0, 8'h00, 0);
      // result backpressure for 10 cycles
      run_word(8'h6F, 4'd4, 8'b0010_0111, 10);

      // in_valid held while busy is ignored: one word yields one result
      bus.in_data  = 8'h03;
      bus.in_valid = 1'b1;
      tick();
      for (int k = 0; k < DATA_W; k++) tick();
      bus.in_valid = 1'b0;
      check("held_valid_done", 32'(bus.out_valid), 32'd1);
      check("held_valid_cnt",  32'(bus.out_count), 32'd1);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check_idle("held_valid_idle");

      // async reset while bit 3 of 8'hFF is on w
      bus.in_data  = 8'hFF;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (4) tick();
      check("pre_reset_w", 32'(bus.w), 32'd1);
      reset = 1'b0;
      #1;
      check_idle("midreset");
      #2;
      reset = 1'b1;
      tick();
      check_idle("post_reset");
      run_word(8'h03, 4'd1, 8'b0000_0001, 0);

`ifdef SECUENCIA_CTRL_ABORT_EN
      // abort during SHIFT cycle 4 of 8'hFF
      bus.in_data  = 8'hFF;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (3) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_idle("abort");
      check("abort_count", 32'(bus.out_count), 32'd0);
      check("abort_map",   32'(bus.out_map),   32'd0);
      repeat (DATA_W) tick();
      check("abort_no_valid", 32'(bus.out_valid), 32'd0);
      // abort in IDLE blocks the accept
      bus.in_data  = 8'hFF;
      bus.in_valid = 1'b1;
      abort        = 1'b1;
      tick();
      abort        = 1'b0;
      bus.in_valid = 1'b0;
      check_idle("abort_idle");
      run_word(8'hC0, 4'd1, 8'b0100_0000, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
